// File: rtl/hid_report_scheduler.sv
// ============================================================================
// Module   : hid_report_scheduler
// Purpose  : Frame-synchronous round-robin sharing of the hex display word
//            between up to four HID report sources, with minimum dwell time.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hid_report_scheduler #(
  parameter int C_sources      = 3,
  parameter int C_data_len     = 64,
  parameter int C_dwell_frames = 30
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  logic [C_sources*C_data_len-1:0] report_i,
  input  logic [C_sources-1:0]            valid_i,
  input  logic                            vsync_i,
  output logic [C_data_len-1:0]           display_o,
  output logic [1:0]                      src_o,
  output logic                            update_o,
  output logic [C_sources-1:0]            pending_o,
  output logic [C_sources-1:0]            overrun_o
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_DWELL = 1'b1
  } state_t;

  localparam logic [1:0] c_last_rst   = 2'(C_sources - 1);
  localparam logic [7:0] c_dwell_load = 8'(C_dwell_frames - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [7:0]            r_cnt;
  logic [7:0]            w_cnt_nxt;
  logic                  r_vs_q;
  logic                  w_tick;
  logic [1:0]            r_last;
  logic [1:0]            w_gnt_idx;
  logic                  w_found;
  logic                  w_any;
  logic                  w_grant;
  logic [C_data_len-1:0] w_gnt_data;
  logic [C_sources-1:0]  w_pending;
  logic [C_sources-1:0]  w_overrun;
  logic [C_data_len-1:0] w_buf [C_sources];
  logic [C_data_len-1:0] r_display;
  logic [1:0]            r_src;
  logic                  r_update;

  assign w_tick = vsync_i & ~r_vs_q;
  assign w_any  = |w_pending;

  // Search order last+1, last+2, ... wrapping at C_sources; first pending wins.
  always_comb begin
    w_gnt_idx = r_last;
    w_found   = 1'b0;
    for (int k = 1; k <= C_sources; k++) begin
      for (int s = 0; s < C_sources; s++) begin
        if (!w_found && w_pending[s] && (s == (int'(r_last) + k) % C_sources)) begin
          w_found   = 1'b1;
          w_gnt_idx = 2'(s);
        end
      end
    end
  end

  always_comb begin
    w_gnt_data = '0;
    for (int s = 0; s < C_sources; s++) begin
      if (2'(s) == w_gnt_idx) begin
        w_gnt_data = w_buf[s];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_grant     = 1'b0;
    if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            w_grant     = 1'b1;
            w_cnt_nxt   = c_dwell_load;
            w_state_nxt = S_DWELL;
          end
        end
        S_DWELL: begin
          if (r_cnt != 8'd0) begin
            w_cnt_nxt = r_cnt - 8'd1;
          end else if (w_any) begin
            w_grant   = 1'b1;
            w_cnt_nxt = c_dwell_load;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_vs_q  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_vs_q  <= vsync_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_display <= '0;
      r_src     <= 2'd0;
      r_update  <= 1'b0;
      r_last    <= c_last_rst;
    end else begin
      r_update <= w_grant;
      if (w_grant) begin
        r_display <= w_gnt_data;
        r_src     <= w_gnt_idx;
        r_last    <= w_gnt_idx;
      end
    end
  end

  for (genvar s = 0; s < C_sources; s++) begin : g_src
    logic                  w_sel;
    logic                  r_pend;
    logic                  r_ovr;
    logic [C_data_len-1:0] r_buf;

    assign w_sel = w_grant && (w_gnt_idx == 2'(s));

    // On a same-cycle grant the display takes the old buffer and the new
    // report stays pending without counting as an overrun.
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        r_buf  <= '0;
        r_pend <= 1'b0;
        r_ovr  <= 1'b0;
      end else if (valid_i[s]) begin
        r_buf  <= report_i[s*C_data_len +: C_data_len];
        r_pend <= 1'b1;
        if (r_pend && !w_sel) begin
          r_ovr <= 1'b1;
        end
      end else if (w_sel) begin
        r_pend <= 1'b0;
      end
    end

    assign w_buf[s]     = r_buf;
    assign w_pending[s] = r_pend;
    assign w_overrun[s] = r_ovr;
  end

  assign display_o = r_display;
  assign src_o     = r_src;
  assign update_o  = r_update;
  assign pending_o = w_pending;
  assign overrun_o = w_overrun;

endmodule

`default_nettype wire

// File: tb/tb_hid_report_scheduler.sv
// Testbench for hid_report_scheduler: three instances (dwell 1, 2, 3) share
// one stimulus stream; each has its own frame-level reference model.
`default_nettype none

module tb_hid_report_scheduler;

  localparam int NS = 3;
  localparam int DL = 64;
  localparam int NI = 3;

  logic             clk    = 1'b0;
  logic             rstn   = 1'b0;
  logic             vsync  = 1'b0;
  logic [NS-1:0]    valid  = '0;
  logic [NS*DL-1:0] report = '0;

  logic [DL-1:0] disp [NI];
  logic [1:0]    src  [NI];
  logic          upd  [NI];
  logic [NS-1:0] pend [NI];
  logic [NS-1:0] ovr  [NI];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar k = 0; k < NI; k++) begin : g_inst
    localparam int DW = k + 1;

    hid_report_scheduler #(
      .C_sources(NS), .C_data_len(DL), .C_dwell_frames(DW)
    ) u_dut (
      .clk_i(clk), .rstn_i(rstn), .report_i(report), .valid_i(valid),
      .vsync_i(vsync), .display_o(disp[k]), .src_o(src[k]), .update_o(upd[k]),
      .pending_o(pend[k]), .overrun_o(ovr[k])
    );

    // Reference: a grant is allowed once at least DW frame ticks have
    // elapsed since the previous grant (or if there never was one).
    logic [DL-1:0] m_buf [NS];
    bit            m_pend [NS];
    bit            m_ovr [NS];
    int            m_last;
    int            m_since;
    bit            m_vs;
    logic [DL-1:0] qd [$];
    int            qs [$];

    always @(posedge clk or negedge rstn) begin
      bit            tick;
      bit            gr;
      int            g;
      logic [DL-1:0] ob [NS];
      bit            op [NS];
      if (!rstn) begin
        for (int s = 0; s < NS; s++) begin
          m_buf[s] = '0; m_pend[s] = 0; m_ovr[s] = 0;
        end
        m_last = NS - 1; m_since = 1000; m_vs = 0;
        qd.delete(); qs.delete();
      end else begin
        tick = vsync && !m_vs;
        m_vs = vsync;
        ob = m_buf; op = m_pend; gr = 0; g = 0;
        if (tick) begin
          if (m_since < 1000) m_since++;
          if (m_since >= DW) begin
            for (int j = 1; j <= NS; j++) begin
              if (!gr && op[(m_last + j) % NS]) begin
                gr = 1; g = (m_last + j) % NS;
              end
            end
          end
          if (gr) begin
            qd.push_back(ob[g]); qs.push_back(g);
            m_last = g; m_since = 0;
          end
        end
        for (int s = 0; s < NS; s++) begin
          if (valid[s]) begin
            if (op[s] && !(gr && g == s)) m_ovr[s] = 1;
            m_buf[s]  = report[s*DL +: DL];
            m_pend[s] = 1;
          end else if (gr && g == s) begin
            m_pend[s] = 0;
          end
        end
      end
    end

    always @(negedge clk) begin
      logic [NS-1:0] ep;
      logic [NS-1:0] eo;
      logic [DL-1:0] ed;
      int            es;
      if (rstn) begin
        for (int s = 0; s < NS; s++) begin
          ep[s] = m_pend[s]; eo[s] = m_ovr[s];
        end
        chk($sformatf("pending_dw%0d", DW), 64'(pend[k]), 64'(ep));
        chk($sformatf("overrun_dw%0d", DW), 64'(ovr[k]), 64'(eo));
        chk($sformatf("update_dw%0d", DW), 64'(upd[k]), 64'(qd.size() > 0));
        if (qd.size() > 0) begin
          ed = qd.pop_front();
          es = qs.pop_front();
          if (upd[k]) begin
            chk($sformatf("display_dw%0d", DW), disp[k], ed);
            chk($sformatf("src_dw%0d", DW), 64'(src[k]), 64'(es));
          end
        end
      end
    end
  end

  function automatic logic [NS*DL-1:0] put(input int s, input logic [DL-1:0] d);
    logic [NS*DL-1:0] r;
    r = '0;
    r[s*DL +: DL] = d;
    return r;
  endfunction

  function automatic logic [NS*DL-1:0] rnd_report();
    logic [NS*DL-1:0] r;
    for (int i = 0; i < NS * 2; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive(input logic [NS-1:0] v, input logic vs, input logic [NS*DL-1:0] r);
    @(negedge clk);
    valid  = v;
    vsync  = vs;
    report = r;
  endtask

  task automatic pulse(input int gap);
    drive('0, 1'b1, rnd_report());
    repeat (gap) drive('0, 1'b0, rnd_report());
  endtask

  task automatic random_phase(input int n);
    logic [NS-1:0] v;
    repeat (n) begin
      for (int s = 0; s < NS; s++) v[s] = ($urandom_range(0, 7) == 0);
      drive(v, ($urandom_range(0, 4) == 0), rnd_report());
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    drive(3'b010, 1'b0, put(1, 64'h1111_2222_3333_4444));
    drive('0, 1'b0, '0);
    pulse(3);

    drive(3'b111, 1'b0, {64'h3, 64'h2, 64'h1});
    drive('0, 1'b0, '0);
    repeat (4) pulse(3);

    drive(3'b100, 1'b0, put(2, 64'hA));
    drive(3'b100, 1'b0, put(2, 64'hB));
    drive('0, 1'b0, '0);
    repeat (4) pulse(2);

    drive(3'b001, 1'b0, put(0, 64'hD));
    drive('0, 1'b0, '0);
    drive(3'b001, 1'b1, put(0, 64'hC));
    drive('0, 1'b0, '0);
    repeat (4) pulse(2);

    random_phase(3000);

    // Asynchronous reset in the middle of a cycle, vsync high at release.
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("rst_display", disp[k], 64'h0);
      chk("rst_src", 64'(src[k]), 64'h0);
      chk("rst_update", 64'(upd[k]), 64'h0);
      chk("rst_pending", 64'(pend[k]), 64'h0);
      chk("rst_overrun", 64'(ovr[k]), 64'h0);
    end
    @(negedge clk);
    vsync = 1'b1;
    valid = '0;
    rstn  = 1'b1;
    drive(3'b111, 1'b1, rnd_report());
    drive('0, 1'b0, '0);
    pulse(4);

    random_phase(1500);
    repeat (6) drive('0, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
